procyon_sram_ctrl: RTL and testbench
====================================

// Module: procyon_sram_ctrl
// PURPOSE
//   Sequencer for the external async 16-bit SRAM (1M x 16, 2MB span). Accepts one DATA_WIDTH-bit
//   read/write request at a time, splits it into DATA_WIDTH/16 SRAM word beats, and drives
//   CE/OE/WE/LB/UB and the data bus with programmable access timing. Returns a one-cycle response.
//   Uses SRAM_* types/widths from procyon_system_pkg.
// PARAMETERS
//   DATA_WIDTH     32  request data width; multiple of 16, >=16; NUM_BEATS = DATA_WIDTH/16
//   ACCESS_CYCLES  2   clock cycles each SRAM beat holds the active strobe (>=1)
// PORTS
//   clk             in   1                  clock
//   n_rst           in   1                  reset, asynchronous, active-low
//   i_req_valid     in   1                  request valid
//   o_req_ready     out  1                  request accepted when valid & ready
//   i_req_we        in   1                  1 = write, 0 = read
//   i_req_addr      in   SRAM_ADDR_WIDTH+1  byte address; low log2(DATA_WIDTH/8) bits ignored
//   i_req_data      in   DATA_WIDTH         write data, beat k = bits[16k+15:16k]
//   i_req_byte_sel  in   DATA_WIDTH/8       write byte enables; beat k uses [2k+1:2k]
//   o_resp_valid    out  1                  one-cycle completion pulse
//   o_resp_we       out  1                  echo of accepted i_req_we, valid with o_resp_valid
//   o_resp_data     out  DATA_WIDTH         read data; meaningful with o_resp_valid & !o_resp_we
//   o_sram_addr     out  SRAM_ADDR_WIDTH    SRAM word address
//   o_sram_dq       out  SRAM_DATA_WIDTH    write data to pad
//   o_sram_dq_oe    out  1                  pad output enable (1 = controller drives DQ)
//   i_sram_dq       in   SRAM_DATA_WIDTH    read data from pad
//   o_sram_ce_n     out  1                  chip enable, active-low
//   o_sram_oe_n     out  1                  output enable, active-low
//   o_sram_we_n     out  1                  write enable, active-low
//   o_sram_lb_n     out  1                  lower byte enable, active-low (DQ[7:0])
//   o_sram_ub_n     out  1                  upper byte enable, active-low (DQ[15:8])
// BEHAVIOUR
//   Reset: state IDLE; all *_n outputs 1; o_sram_dq_oe 0; o_sram_addr/o_sram_dq 0; o_req_ready 1;
//     o_resp_valid/o_resp_we 0; o_resp_data 0. Reset mid-access aborts at once, no response issued.
//   All SRAM-facing outputs registered; no combinational path from i_sram_dq to any output.
//   States: IDLE, READ, WRITE, WRITE_HOLD, DONE. o_req_ready = (state == IDLE).
//   IDLE: on accept latch we/addr/data/byte_sel, beat=0 -> READ or WRITE (first non-skipped beat).
//   Beat word address = {addr[20:1] with beat-index bits cleared} + beat; alignment => never wraps.
//   READ: ce_n=0, oe_n=0, lb_n=ub_n=0, dq_oe=0 for ACCESS_CYCLES cycles; i_sram_dq sampled on the
//     last edge into o_resp_data[16*beat +: 16]; then next beat or DONE.
//   WRITE: ce_n=0, we_n=0, oe_n=1, dq_oe=1, lb_n/ub_n = ~byte_sel pair, for ACCESS_CYCLES cycles.
//   WRITE_HOLD: 1 cycle, we_n=1, ce_n=0, addr/dq/dq_oe held (hold time); then next beat or DONE.
//   Write beats with byte_sel pair == 2'b00 are skipped (no SRAM cycle); all skipped -> DONE directly.
//   Reads ignore byte_sel; always all bytes.
//   DONE: 1 cycle, o_resp_valid=1, all strobes inactive, dq_oe=0; -> IDLE. No response backpressure.
//   Latency acceptance edge -> o_resp_valid high: read NUM_BEATS*ACCESS_CYCLES cycles;
//     write (non-skipped beats)*(ACCESS_CYCLES+1) cycles; all-skipped write 1 cycle.
//   Back-to-back: next request accepted no earlier than the cycle after DONE (IDLE).
//   o_resp_data holds last read value across writes and idle.
// TESTING
//   Read 0x000004 (32b, AC=2), SRAM returns 0xBEEF@word2, 0xCAFE@word3 -> addr 2 then 3, 2 cyc each,
//     resp_valid 4 cyc after accept, o_resp_data=0xCAFEBEEF, oe_n low only during beats.
//   Write 0x000008 data 0x11223344 sel 4'b1100 -> word4 skipped; word5 dq=0x1122, we_n low 2 cyc,
//     hold 1 cyc, lb/ub=0; resp_valid 3 cyc after accept, o_resp_we=1.
//   Write sel 4'b0001 -> single beat word0, lb_n=0, ub_n=1; sel 4'b0000 -> no ce_n, resp next cycle.
//   Read 0x1FFFFC -> words 0xFFFFE, 0xFFFFF; no wrap to 0.
//   i_req_valid held high, alternating we -> one accept per transaction, ready low until IDLE,
//     dq_oe never 1 while oe_n=0.
//   n_rst low mid-WRITE -> all *_n=1, dq_oe=0 immediately; no resp_valid; next request serviced normally.

Source files
------------

// File: rtl/procyon_sram_ctrl.sv
// Sequencer for the external async 16-bit SRAM: splits one wide request into 16-bit beats
// and drives the SRAM strobes and data bus with programmable access timing.

package procyon_system_pkg;
   localparam int SRAM_ADDR_WIDTH = 20;
   localparam int SRAM_DATA_WIDTH = 16;
   typedef logic [SRAM_ADDR_WIDTH-1:0] sram_addr_t;
   typedef logic [SRAM_DATA_WIDTH-1:0] sram_data_t;
endpackage

module procyon_sram_ctrl
   import procyon_system_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     i_req_valid,
   output logic                     o_req_ready,
   input  logic                     i_req_we,
   input  logic [SRAM_ADDR_WIDTH:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0]    i_req_data,
   input  logic [DATA_WIDTH/8-1:0]  i_req_byte_sel,
   output logic                     o_resp_valid,
   output logic                     o_resp_we,
   output logic [DATA_WIDTH-1:0]    o_resp_data,
   output sram_addr_t               o_sram_addr,
   output sram_data_t               o_sram_dq,
   output logic                     o_sram_dq_oe,
   input  sram_data_t               i_sram_dq,
   output logic                     o_sram_ce_n,
   output logic                     o_sram_oe_n,
   output logic                     o_sram_we_n,
   output logic                     o_sram_lb_n,
   output logic                     o_sram_ub_n
);

   localparam int NUM_BEATS = DATA_WIDTH / 16;
   localparam int BYTES     = DATA_WIDTH / 8;
   localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int CNT_W     = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam sram_addr_t BEAT_MASK = sram_addr_t'(NUM_BEATS - 1);

   typedef enum logic [2:0] {IDLE, READ, WRITE, WRITE_HOLD, DONE} state_t;

   state_t            state;
   sram_addr_t        req_base;
   logic [DATA_WIDTH-1:0] req_data;
   logic [BYTES-1:0]  req_sel;
   logic [BEAT_W-1:0] beat;
   logic [CNT_W-1:0]  cnt;

   sram_addr_t        in_base;
   sram_addr_t        src_base;
   logic [DATA_WIDTH-1:0] src_data;
   logic [BYTES-1:0]  src_sel;
   logic [BEAT_W:0]   hit;
   logic              hit_found;
   logic [BEAT_W-1:0] hit_idx;
   sram_addr_t        wr_addr;
   sram_data_t        wr_dq;
   logic              wr_lb_n;
   logic              wr_ub_n;
   logic              beat_last;
   logic              cnt_last;

   // Lowest beat at or above 'start' whose byte-enable pair is non-zero; MSB flags a hit.
   function automatic logic [BEAT_W:0] next_beat(input logic [BYTES-1:0] sel, input int start);
      logic [BEAT_W:0] r;
      r = '0;
      for (int k = NUM_BEATS - 1; k >= 0; k--) begin
         if (k >= start && sel[2*k +: 2] != 2'b00) begin
            r = {1'b1, BEAT_W'(k)};
         end
      end
      return r;
   endfunction

   assign o_req_ready = (state == IDLE);
   assign in_base     = sram_addr_t'(i_req_addr >> 1) & ~BEAT_MASK;
   assign beat_last   = (beat == BEAT_W'(NUM_BEATS - 1));
   assign cnt_last    = (cnt == CNT_W'(ACCESS_CYCLES - 1));

   // Next write beat: taken from the live request when idle, else from the latched one.
   always_comb begin
      src_base  = (state == IDLE) ? in_base : req_base;
      src_data  = (state == IDLE) ? i_req_data : req_data;
      src_sel   = (state == IDLE) ? i_req_byte_sel : req_sel;
      hit       = next_beat(src_sel, (state == IDLE) ? 0 : int'(beat) + 1);
      hit_found = hit[BEAT_W];
      hit_idx   = hit[BEAT_W-1:0];
      wr_addr   = src_base + sram_addr_t'(hit_idx);
      wr_dq     = src_data[16*int'(hit_idx) +: 16];
      wr_lb_n   = ~src_sel[2*int'(hit_idx)];
      wr_ub_n   = ~src_sel[2*int'(hit_idx) + 1];
   end

   // Single sequencer; every SRAM-facing output is a flop so pad timing is clean.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         req_base     <= '0;
         req_data     <= '0;
         req_sel      <= '0;
         beat         <= '0;
         cnt          <= '0;
         o_resp_valid <= 1'b0;
         o_resp_we    <= 1'b0;
         o_resp_data  <= '0;
         o_sram_addr  <= '0;
         o_sram_dq    <= '0;
         o_sram_dq_oe <= 1'b0;
         o_sram_ce_n  <= 1'b1;
         o_sram_oe_n  <= 1'b1;
         o_sram_we_n  <= 1'b1;
         o_sram_lb_n  <= 1'b1;
         o_sram_ub_n  <= 1'b1;
      end else begin
         o_resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req_valid) begin
                  req_base  <= in_base;
                  req_data  <= i_req_data;
                  req_sel   <= i_req_byte_sel;
                  o_resp_we <= i_req_we;
                  cnt       <= '0;
                  if (!i_req_we) begin
                     state        <= READ;
                     beat         <= '0;
                     o_sram_addr  <= in_base;
                     o_sram_ce_n  <= 1'b0;
                     o_sram_oe_n  <= 1'b0;
                     o_sram_lb_n  <= 1'b0;
                     o_sram_ub_n  <= 1'b0;
                     o_sram_dq_oe <= 1'b0;
                  end else if (hit_found) begin
                     state        <= WRITE;
                     beat         <= hit_idx;
                     o_sram_addr  <= wr_addr;
                     o_sram_dq    <= wr_dq;
                     o_sram_lb_n  <= wr_lb_n;
                     o_sram_ub_n  <= wr_ub_n;
                     o_sram_ce_n  <= 1'b0;
                     o_sram_we_n  <= 1'b0;
                     o_sram_oe_n  <= 1'b1;
                     o_sram_dq_oe <= 1'b1;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            READ: begin
               if (cnt_last) begin
                  o_resp_data[16*int'(beat) +: 16] <= i_sram_dq;
                  cnt <= '0;
                  if (beat_last) begin
                     state        <= DONE;
                     o_resp_valid <= 1'b1;
                     o_sram_ce_n  <= 1'b1;
                     o_sram_oe_n  <= 1'b1;
                     o_sram_lb_n  <= 1'b1;
                     o_sram_ub_n  <= 1'b1;
                  end else begin
                     beat        <= beat + 1'b1;
                     o_sram_addr <= req_base + sram_addr_t'(int'(beat) + 1);
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WRITE: begin
               if (cnt_last) begin
                  state       <= WRITE_HOLD;
                  o_sram_we_n <= 1'b1;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WRITE_HOLD: begin
               if (hit_found) begin
                  state       <= WRITE;
                  beat        <= hit_idx;
                  o_sram_addr <= wr_addr;
                  o_sram_dq   <= wr_dq;
                  o_sram_lb_n <= wr_lb_n;
                  o_sram_ub_n <= wr_ub_n;
                  o_sram_we_n <= 1'b0;
               end else begin
                  state        <= DONE;
                  o_resp_valid <= 1'b1;
                  o_sram_ce_n  <= 1'b1;
                  o_sram_lb_n  <= 1'b1;
                  o_sram_ub_n  <= 1'b1;
                  o_sram_dq_oe <= 1'b0;
               end
            end
            DONE: begin
               // An all-skipped write arrives here without a pulse and raises it one cycle later.
               if (!o_resp_valid) begin
                  o_resp_valid <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_procyon_sram_ctrl.sv
// Self-checking bench for procyon_sram_ctrl: a transaction-level model expands each accepted
// request into the expected per-cycle SRAM trace, compared against the DUT every cycle.

module tb_procyon_sram_ctrl;
   import procyon_system_pkg::*;

   localparam int AC = 2;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic        i_req_we = 1'b0;
   logic [20:0] i_req_addr = '0;
   logic [31:0] i_req_data = '0;
   logic [3:0]  i_req_byte_sel = '0;
   logic        o_resp_valid;
   logic        o_resp_we;
   logic [31:0] o_resp_data;
   sram_addr_t  o_sram_addr;
   sram_data_t  o_sram_dq;
   logic        o_sram_dq_oe;
   sram_data_t  i_sram_dq = '0;
   logic        o_sram_ce_n;
   logic        o_sram_oe_n;
   logic        o_sram_we_n;
   logic        o_sram_lb_n;
   logic        o_sram_ub_n;

   procyon_sram_ctrl #(.DATA_WIDTH(32), .ACCESS_CYCLES(AC)) dut (
      .clk(clk), .n_rst(n_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_byte_sel(i_req_byte_sel),
      .o_resp_valid(o_resp_valid), .o_resp_we(o_resp_we), .o_resp_data(o_resp_data),
      .o_sram_addr(o_sram_addr), .o_sram_dq(o_sram_dq), .o_sram_dq_oe(o_sram_dq_oe),
      .i_sram_dq(i_sram_dq), .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n),
      .o_sram_we_n(o_sram_we_n), .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit ready; bit rv; bit rwe;
      logic [31:0] rdata; bit chk_rdata;
      bit ce_n; bit oe_n; bit we_n;
      bit chk_lbub; bit lb_n; bit ub_n;
      bit dq_oe;
      bit chk_addr; logic [19:0] addr;
      bit chk_dq; logic [15:0] dq;
   } exp_t;

   exp_t        q[$];
   logic [15:0] mem [int unsigned];
   logic [31:0] last_read = '0;
   int          total = 0;
   int          bad = 0;
   bit          cur_idle;

   bit          tracking = 0;
   int          tx_cycles, tx_lat, tx_ce_low, tx_we_low;
   logic [19:0] tx_first_addr, tx_last_addr, tx_we_addr;
   logic [15:0] tx_we_dq;
   logic        tx_lb, tx_ub;
   logic [31:0] tx_rdata;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem_rd(input logic [19:0] a);
      int unsigned v;
      if (mem.exists(int'(a))) return mem[int'(a)];
      v = (int'(a) * 40503) ^ 32'h5A5A;
      return v[15:0];
   endfunction

   function automatic exp_t blank();
      exp_t e;
      e.ready = 0; e.rv = 0; e.rwe = 0; e.rdata = last_read; e.chk_rdata = 1;
      e.ce_n = 1; e.oe_n = 1; e.we_n = 1; e.chk_lbub = 1; e.lb_n = 1; e.ub_n = 1;
      e.dq_oe = 0; e.chk_addr = 0; e.addr = '0; e.chk_dq = 0; e.dq = '0;
      return e;
   endfunction

   // Expand one accepted request into the cycles that must follow the acceptance edge.
   task automatic push_trace(input bit we, input logic [20:0] addr, input logic [31:0] data,
                             input logic [3:0] sel);
      logic [19:0] base, w;
      logic [15:0] old;
      logic [1:0]  pair;
      exp_t        e;
      int          n = 0;
      base = 20'((int'(addr) / 4) * 2);
      if (!we) begin
         for (int b = 0; b < 2; b++) begin
            w = base + 20'(b);
            for (int c = 0; c < AC; c++) begin
               e = blank();
               e.chk_rdata = 0; e.ce_n = 0; e.oe_n = 0; e.lb_n = 0; e.ub_n = 0;
               e.chk_addr = 1; e.addr = w;
               q.push_back(e);
            end
         end
         last_read = {mem_rd(base + 20'd1), mem_rd(base)};
         e = blank();
         e.rv = 1; e.rwe = 0;
         q.push_back(e);
      end else begin
         for (int b = 0; b < 2; b++) begin
            pair = sel[2*b +: 2];
            if (pair != 2'b00) begin
               n++;
               w = base + 20'(b);
               for (int c = 0; c <= AC; c++) begin
                  e = blank();
                  e.ce_n = 0; e.we_n = (c == AC); e.oe_n = 1; e.dq_oe = 1;
                  e.chk_lbub = (c < AC); e.lb_n = ~pair[0]; e.ub_n = ~pair[1];
                  e.chk_addr = 1; e.addr = w; e.chk_dq = 1; e.dq = data[16*b +: 16];
                  q.push_back(e);
               end
               old = mem_rd(w);
               if (pair[0]) old[7:0] = data[16*b +: 8];
               if (pair[1]) old[15:8] = data[16*b + 8 +: 8];
               mem[int'(w)] = old;
            end
         end
         if (n == 0) q.push_back(blank());
         e = blank();
         e.rv = 1; e.rwe = 1;
         q.push_back(e);
      end
   endtask

   // One clock: compare this cycle's outputs against the model, then answer the SRAM read.
   task automatic step();
      exp_t e;
      bit   busy;
      @(negedge clk);
      busy = (q.size() != 0);
      if (busy) e = q.pop_front();
      else begin
         e = blank();
         e.ready = 1;
      end
      cur_idle = !busy;
      checkOutput("req_ready", 32'(o_req_ready), 32'(e.ready));
      checkOutput("resp_valid", 32'(o_resp_valid), 32'(e.rv));
      checkOutput("ce_n", 32'(o_sram_ce_n), 32'(e.ce_n));
      checkOutput("oe_n", 32'(o_sram_oe_n), 32'(e.oe_n));
      checkOutput("we_n", 32'(o_sram_we_n), 32'(e.we_n));
      checkOutput("dq_oe", 32'(o_sram_dq_oe), 32'(e.dq_oe));
      checkOutput("dq_oe_with_oe_n_low", 32'(o_sram_dq_oe & ~o_sram_oe_n), 32'(0));
      if (e.rv) checkOutput("resp_we", 32'(o_resp_we), 32'(e.rwe));
      if (e.chk_rdata) checkOutput("resp_data", o_resp_data, e.rdata);
      if (e.chk_lbub) begin
         checkOutput("lb_n", 32'(o_sram_lb_n), 32'(e.lb_n));
         checkOutput("ub_n", 32'(o_sram_ub_n), 32'(e.ub_n));
      end
      if (e.chk_addr) checkOutput("sram_addr", 32'(o_sram_addr), 32'(e.addr));
      if (e.chk_dq) checkOutput("sram_dq", 32'(o_sram_dq), 32'(e.dq));
      if (tracking) begin
         tx_cycles++;
         if (!o_sram_ce_n) begin
            if (tx_ce_low == 0) tx_first_addr = o_sram_addr;
            tx_last_addr = o_sram_addr;
            tx_ce_low++;
         end
         if (!o_sram_we_n) begin
            tx_we_low++;
            tx_we_addr = o_sram_addr;
            tx_we_dq = o_sram_dq;
            tx_lb = o_sram_lb_n;
            tx_ub = o_sram_ub_n;
         end
         if (o_resp_valid && tx_lat < 0) begin
            tx_lat = tx_cycles - 1;
            tx_rdata = o_resp_data;
         end
      end
      if (!o_sram_ce_n && !o_sram_oe_n) i_sram_dq = mem_rd(o_sram_addr);
      else i_sram_dq = 16'($urandom);
   endtask

   task automatic applyStimulus(input bit v, input bit we, input logic [20:0] addr,
                                input logic [31:0] data, input logic [3:0] sel);
      i_req_valid = v;
      i_req_we = we;
      i_req_addr = addr;
      i_req_data = data;
      i_req_byte_sel = sel;
      if (cur_idle && v && n_rst) push_trace(we, addr, data, sel);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (!cur_idle && guard < 200) begin
         step();
         guard++;
      end
      checkOutput("idle_within_budget", 32'(cur_idle), 32'(1));
   endtask

   // Directed transaction with latency and strobe statistics collected for literal checks.
   task automatic run_txn(input bit we, input logic [20:0] addr, input logic [31:0] data,
                          input logic [3:0] sel);
      int guard = 0;
      wait_idle();
      tracking = 1; tx_cycles = 0; tx_lat = -1; tx_ce_low = 0; tx_we_low = 0;
      tx_first_addr = '0; tx_last_addr = '0; tx_we_addr = '0; tx_we_dq = '0;
      tx_lb = 1; tx_ub = 1; tx_rdata = '0;
      applyStimulus(1, we, addr, data, sel);
      step();
      applyStimulus(0, 0, '0, '0, '0);
      while ((q.size() != 0 || tx_lat < 0) && guard < 200) begin
         step();
         guard++;
      end
      checkOutput("txn_completes", 32'(tx_lat >= 0), 32'(1));
      tracking = 0;
   endtask

   function automatic logic [20:0] rand_addr();
      case ($urandom_range(0, 2))
         0: return 21'($urandom_range(0, 63));
         1: return 21'h1FFFC0 + 21'($urandom_range(0, 63));
         default: return 21'($urandom);
      endcase
   endfunction

   initial begin
      cur_idle = 1;
      step();
      step();
      n_rst = 1'b1;
      step();

      mem[2] = 16'hBEEF;
      mem[3] = 16'hCAFE;
      run_txn(0, 21'h000004, '0, '0);
      checkOutput("lit_read_latency", 32'(tx_lat), 32'd4);
      checkOutput("lit_read_data", tx_rdata, 32'hCAFEBEEF);
      checkOutput("lit_read_first_addr", 32'(tx_first_addr), 32'd2);
      checkOutput("lit_read_last_addr", 32'(tx_last_addr), 32'd3);
      checkOutput("lit_read_ce_cycles", 32'(tx_ce_low), 32'd4);

      run_txn(1, 21'h000008, 32'h11223344, 4'b1100);
      checkOutput("lit_wr_latency", 32'(tx_lat), 32'd3);
      checkOutput("lit_wr_we_cycles", 32'(tx_we_low), 32'd2);
      checkOutput("lit_wr_addr", 32'(tx_we_addr), 32'd5);
      checkOutput("lit_wr_dq", 32'(tx_we_dq), 32'h1122);
      checkOutput("lit_wr_lb_ub", 32'({tx_ub, tx_lb}), 32'd0);
      checkOutput("lit_wr_ce_cycles", 32'(tx_ce_low), 32'd3);
      checkOutput("lit_model_mem5", 32'(mem_rd(20'd5)), 32'h1122);

      run_txn(1, 21'h000000, 32'h000000AB, 4'b0001);
      checkOutput("lit_wr1_latency", 32'(tx_lat), 32'd3);
      checkOutput("lit_wr1_addr", 32'(tx_we_addr), 32'd0);
      checkOutput("lit_wr1_lb_ub", 32'({tx_ub, tx_lb}), 32'b10);

      run_txn(1, 21'h000010, 32'h55667788, 4'b0000);
      checkOutput("lit_skip_latency", 32'(tx_lat), 32'd1);
      checkOutput("lit_skip_ce_cycles", 32'(tx_ce_low), 32'd0);

      run_txn(0, 21'h1FFFFC, '0, '0);
      checkOutput("lit_top_first_addr", 32'(tx_first_addr), 32'hFFFFE);
      checkOutput("lit_top_last_addr", 32'(tx_last_addr), 32'hFFFFF);
      checkOutput("lit_top_latency", 32'(tx_lat), 32'd4);

      // Abort a write mid-beat; the controller must release the bus at once.
      wait_idle();
      applyStimulus(1, 1, 21'h000020, 32'hA5A55A5A, 4'hF);
      step();
      applyStimulus(0, 0, '0, '0, '0);
      step();
      step();
      n_rst = 1'b0;
      #1;
      checkOutput("rst_ce_n", 32'(o_sram_ce_n), 32'd1);
      checkOutput("rst_we_n", 32'(o_sram_we_n), 32'd1);
      checkOutput("rst_oe_n", 32'(o_sram_oe_n), 32'd1);
      checkOutput("rst_lb_ub", 32'({o_sram_ub_n, o_sram_lb_n}), 32'b11);
      checkOutput("rst_dq_oe", 32'(o_sram_dq_oe), 32'd0);
      checkOutput("rst_ready", 32'(o_req_ready), 32'd1);
      q.delete();
      last_read = '0;
      step();
      step();
      n_rst = 1'b1;
      step();
      run_txn(0, 21'h000004, '0, '0);
      checkOutput("post_rst_read_latency", 32'(tx_lat), 32'd4);
      checkOutput("post_rst_read_data", tx_rdata, 32'hCAFEBEEF);

      // Valid held high with alternating direction, then fully random traffic.
      for (int c = 0; c < 600; c++) begin
         step();
         applyStimulus(1, c[0], rand_addr(), $urandom, 4'($urandom));
      end
      for (int c = 0; c < 1500; c++) begin
         step();
         applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, rand_addr(),
                       $urandom, 4'($urandom));
      end
      applyStimulus(0, 0, '0, '0, '0);
      wait_idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
